// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam logic [7:0] RESET_PC_DEF = 8'h00;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO; top_data is the most recently pushed entry.
module return_stack #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] mem_q [DEPTH];

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign top_data = mem_q[count_q[PTR_W-1:0] - PTR_W'(1)];

    always_comb begin
        count_d = count_q;
        if (push && !full) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !empty) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
        if (!reset && push && !full) begin
            mem_q[count_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch stage: PC, imem req/ack, and next-PC selection.
// Return stack for call/ret is built only with FETCH_SEQUENCER_RETURN_STACK_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                DATA_W      = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(RESET_PC_DEF),
    parameter int                STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              call,
    input  logic              ret,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              halted,
    output logic              stack_err
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_inc;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              imem_req_q, imem_req_d;
    logic              consume;

    assign consume     = (state_q == ISSUE) && !stall;
    assign pc_inc      = pc_q + ADDR_W'(1);
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = imem_req_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign halted      = (state_q == HALT);

`ifdef FETCH_SEQUENCER_RETURN_STACK_EN
    logic              stk_push, stk_pop, stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_top;
    logic              err_set, stack_err_q, stack_err_d;

    return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    assign stack_err_d = stack_err_q | err_set;
    assign stack_err   = stack_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stack_err_q <= 1'b0;
        end else begin
            stack_err_q <= stack_err_d;
        end
    end
`else
    logic unused_ret;
    assign unused_ret = ret ^ STACK_DEPTH[0];
    assign stack_err  = 1'b0;
`endif

    // Next-PC selection; only meaningful when an instruction is consumed.
    always_comb begin
        pc_next = pc_q;
`ifdef FETCH_SEQUENCER_RETURN_STACK_EN
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        err_set  = 1'b0;
`endif
        if (consume && !halt) begin
`ifdef FETCH_SEQUENCER_RETURN_STACK_EN
            if (call && ret) begin
                err_set = 1'b1;
                pc_next = pc_inc;
            end else if (ret) begin
                if (stk_empty) begin
                    err_set = 1'b1;
                    pc_next = pc_inc;
                end else begin
                    stk_pop = 1'b1;
                    pc_next = stk_top;
                end
            end else if (call) begin
                stk_push = !stk_full;
                err_set  = stk_full;
                pc_next  = branch_target;
            end else if (branch_taken) begin
                pc_next = branch_target;
            end else begin
                pc_next = pc_inc;
            end
`else
            if (call || branch_taken) begin
                pc_next = branch_target;
            end else begin
                pc_next = pc_inc;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_next;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (imem_ack) state_d = ISSUE;
            ISSUE:   if (!stall) state_d = halt ? HALT : FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // imem_req is registered, so it follows the state being entered.
    always_comb begin
        imem_req_d    = (state_d == FETCH);
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        if (state_q == FETCH && imem_ack) begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
        end else if (consume) begin
            instr_valid_d = 1'b0;
        end
    end

endmodule
